// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg: shared types and helpers for the main-memory port arbiter.
// Optional build macro used by the arbiter: MEM_PORT_ARB_PERF_EN.
package mem_port_arb_pkg;

  // Requester identity; also the value stored in the response-routing FIFO.
  typedef enum logic {
    REQ_DATA  = 1'b0,
    REQ_INSTR = 1'b1
  } req_id_e;

  localparam int NUM_REQ = 2;

  // Pointer width for a FIFO of the given depth; never narrower than 1 bit.
  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_port_arb_id_fifo.sv
// mem_port_arb_id_fifo: small FIFO of requester IDs. Records which port issued
// each accepted memory transaction so in-order responses can be routed back.
// Push is ignored when full, pop is ignored when empty; both in one cycle keep
// the count unchanged and preserve order. Pointers wrap modulo DEPTH.
module mem_port_arb_id_fifo
  import mem_port_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk_i,
  input  logic    rstn_i,
  input  logic    push_i,
  input  req_id_e push_id_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output req_id_e head_o
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  req_id_e          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  // Storage and write pointer: write the new ID at the tail on push.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= REQ_DATA;
      end
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= push_id_i;
      r_wr_ptr        <= next_ptr(r_wr_ptr);
    end
  end

  // Read pointer: advance past the head on pop.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rd_ptr <= '0;
    end else if (w_pop) begin
      r_rd_ptr <= next_ptr(r_rd_ptr);
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one main-memory port between the data side (port 0)
// and the instruction-fetch side (port 1). Round-robin between simultaneous
// requests, bounded outstanding transactions, in-order response routing.
// Optional build macro: MEM_PORT_ARB_PERF_EN adds per-port grant/stall counters.
//
// Handshake: a requester raises mN_req with stable attributes until mN_gnt;
// a transfer happens in any cycle with memory_req && memory_gnt. Each transfer
// yields exactly one memory_rvalid, in issue order, at least one cycle later.
module mem_port_arbiter
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic                  m0_we,
  input  logic [3:0]            m0_be,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic                  m1_we,
  input  logic [3:0]            m1_be,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  memory_req,
  output logic [31:0]           memory_addr,
  output logic                  memory_we,
  output logic [3:0]            memory_be,
  output logic [31:0]           memory_wdata,
  input  logic                  memory_gnt,
  input  logic                  memory_rvalid,
  input  logic [31:0]           memory_rdata,
  output logic                  proto_err_o
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]           perf0_grants_o,
  output logic [31:0]           perf0_stall_o,
  output logic [31:0]           perf1_grants_o,
  output logic [31:0]           perf1_stall_o
`endif
);

  req_id_e r_prio;
  logic    r_proto_err;

  req_id_e w_sel;
  req_id_e w_head;
  logic    w_any_req;
  logic    w_fifo_full;
  logic    w_fifo_empty;
  logic    w_xfer;
  logic    w_resp_ok;

  // Port selection: a lone requester wins; a tie goes to the priority pointer.
  always_comb begin
    w_sel = REQ_DATA;
    if (m0_req && m1_req) begin
      w_sel = r_prio;
    end else if (m1_req) begin
      w_sel = REQ_INSTR;
    end
  end

  // Admission looks only at the registered occupancy, so a pop in the same
  // cycle does not reopen a full FIFO until the following cycle.
  assign w_any_req  = m0_req || m1_req;
  assign memory_req = rstn_i && w_any_req && !w_fifo_full;
  assign w_xfer     = memory_req && memory_gnt;

  // Request attribute mux; everything reads zero while no request is driven.
  always_comb begin
    memory_addr  = '0;
    memory_we    = 1'b0;
    memory_be    = '0;
    memory_wdata = '0;
    if (memory_req) begin
      if (w_sel == REQ_INSTR) begin
        memory_addr  = 32'(m1_addr);
        memory_we    = m1_we;
        memory_be    = m1_be;
        memory_wdata = m1_wdata;
      end else begin
        memory_addr  = 32'(m0_addr);
        memory_we    = m0_we;
        memory_be    = m0_be;
        memory_wdata = m0_wdata;
      end
    end
  end

  assign m0_gnt = w_xfer && (w_sel == REQ_DATA);
  assign m1_gnt = w_xfer && (w_sel == REQ_INSTR);

  // Priority pointer: after each transfer the other port is favoured.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_prio <= REQ_DATA;
    end else if (w_xfer) begin
      r_prio <= (w_sel == REQ_DATA) ? REQ_INSTR : REQ_DATA;
    end
  end

  mem_port_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .push_i    (w_xfer),
    .push_id_i (w_sel),
    .pop_i     (memory_rvalid),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty),
    .head_o    (w_head)
  );

  // Responses are routed to the port at the FIFO head; orphans go nowhere.
  assign w_resp_ok = rstn_i && memory_rvalid && !w_fifo_empty;
  assign m0_rvalid = w_resp_ok && (w_head == REQ_DATA);
  assign m1_rvalid = w_resp_ok && (w_head == REQ_INSTR);
  assign m0_rdata  = m0_rvalid ? memory_rdata : '0;
  assign m1_rdata  = m1_rvalid ? memory_rdata : '0;

  // Sticky protocol error: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_proto_err <= 1'b0;
    end else if (memory_rvalid && w_fifo_empty) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err_o = r_proto_err;

`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] r_perf0_grants;
  logic [31:0] r_perf0_stall;
  logic [31:0] r_perf1_grants;
  logic [31:0] r_perf1_stall;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating per-port grant and stall counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_perf0_grants <= '0;
      r_perf0_stall  <= '0;
      r_perf1_grants <= '0;
      r_perf1_stall  <= '0;
    end else begin
      if (m0_gnt)           r_perf0_grants <= sat_inc(r_perf0_grants);
      if (m0_req && !m0_gnt) r_perf0_stall  <= sat_inc(r_perf0_stall);
      if (m1_gnt)           r_perf1_grants <= sat_inc(r_perf1_grants);
      if (m1_req && !m1_gnt) r_perf1_stall  <= sat_inc(r_perf1_stall);
    end
  end

  assign perf0_grants_o = r_perf0_grants;
  assign perf0_stall_o  = r_perf0_stall;
  assign perf1_grants_o = r_perf1_grants;
  assign perf1_stall_o  = r_perf1_stall;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level reference model (queue of issuing port IDs).
module tb_mem_port_arbiter;

  localparam int MAX_OUT = 2;

  logic        clk;
  logic        rstn;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        memory_req, memory_we, memory_gnt, memory_rvalid;
  logic [31:0] memory_addr, memory_wdata, memory_rdata;
  logic [3:0]  memory_be;
  logic        proto_err;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf0_grants, perf0_stall, perf1_grants, perf1_stall;
  logic [31:0] m_grants [2];
  logic [31:0] m_stall  [2];
`endif

  // Stimulus state (what the requesters and memory want to drive).
  logic        s_rstn;
  logic        s_req   [2];
  logic [31:0] s_addr  [2];
  logic        s_we    [2];
  logic [3:0]  s_be    [2];
  logic [31:0] s_wdata [2];
  logic        s_mgnt, s_rvalid;
  logic [31:0] s_rdata;

  // Reference model state.
  logic [0:0]  exp_q [$];
  logic        m_prio;
  logic        m_err;
  logic [1:0]  m_gnt;

  // DUT values captured at the check point of the last step.
  logic [1:0]  d_gnt, d_rv;
  logic        d_mreq;
  logic [31:0] d_rdata0;

  int n_checks;
  int n_fail;

  mem_port_arbiter #(
    .ADDR_WIDTH      (32),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk_i (clk), .rstn_i (rstn),
    .m0_req (m0_req), .m0_addr (m0_addr), .m0_we (m0_we), .m0_be (m0_be),
    .m0_wdata (m0_wdata), .m0_gnt (m0_gnt), .m0_rvalid (m0_rvalid), .m0_rdata (m0_rdata),
    .m1_req (m1_req), .m1_addr (m1_addr), .m1_we (m1_we), .m1_be (m1_be),
    .m1_wdata (m1_wdata), .m1_gnt (m1_gnt), .m1_rvalid (m1_rvalid), .m1_rdata (m1_rdata),
    .memory_req (memory_req), .memory_addr (memory_addr), .memory_we (memory_we),
    .memory_be (memory_be), .memory_wdata (memory_wdata), .memory_gnt (memory_gnt),
    .memory_rvalid (memory_rvalid), .memory_rdata (memory_rdata),
    .proto_err_o (proto_err)
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    .perf0_grants_o (perf0_grants), .perf0_stall_o (perf0_stall),
    .perf1_grants_o (perf1_grants), .perf1_stall_o (perf1_stall)
`endif
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, update model at posedge.
  task automatic step();
    logic        emreq, esel, ewe;
    logic [1:0]  ev;
    logic [31:0] ea, ew, erd0, erd1;
    logic [3:0]  ebe;
    @(negedge clk);
    rstn = s_rstn;
    m0_req = s_req[0]; m0_addr = s_addr[0]; m0_we = s_we[0]; m0_be = s_be[0]; m0_wdata = s_wdata[0];
    m1_req = s_req[1]; m1_addr = s_addr[1]; m1_we = s_we[1]; m1_be = s_be[1]; m1_wdata = s_wdata[1];
    memory_gnt = s_mgnt; memory_rvalid = s_rvalid; memory_rdata = s_rdata;
    #1;
    if (!rstn) begin
      exp_q.delete();
      m_prio = 1'b0;
      m_err  = 1'b0;
`ifdef MEM_PORT_ARB_PERF_EN
      for (int n = 0; n < 2; n++) begin m_grants[n] = '0; m_stall[n] = '0; end
`endif
    end
    emreq = rstn && (s_req[0] || s_req[1]) && (exp_q.size() < MAX_OUT);
    esel  = (s_req[0] && s_req[1]) ? m_prio : s_req[1];
    m_gnt = 2'b00;
    if (emreq && s_mgnt) m_gnt[esel] = 1'b1;
    ea  = emreq ? s_addr[esel]  : 32'h0;
    ewe = emreq ? s_we[esel]    : 1'b0;
    ebe = emreq ? s_be[esel]    : 4'h0;
    ew  = emreq ? s_wdata[esel] : 32'h0;
    ev  = 2'b00;
    if (rstn && s_rvalid && exp_q.size() > 0) ev[exp_q[0]] = 1'b1;
    erd0 = ev[0] ? s_rdata : 32'h0;
    erd1 = ev[1] ? s_rdata : 32'h0;
    check_eq("memory_req",   32'(memory_req), 32'(emreq));
    check_eq("memory_addr",  memory_addr, ea);
    check_eq("memory_we",    32'(memory_we), 32'(ewe));
    check_eq("memory_be",    32'(memory_be), 32'(ebe));
    check_eq("memory_wdata", memory_wdata, ew);
    check_eq("gnt",          32'({m1_gnt, m0_gnt}), 32'(m_gnt));
    check_eq("rvalid",       32'({m1_rvalid, m0_rvalid}), 32'(ev));
    check_eq("m0_rdata",     m0_rdata, erd0);
    check_eq("m1_rdata",     m1_rdata, erd1);
    check_eq("proto_err",    32'(proto_err), 32'(m_err));
`ifdef MEM_PORT_ARB_PERF_EN
    check_eq("perf0_grants", perf0_grants, m_grants[0]);
    check_eq("perf0_stall",  perf0_stall,  m_stall[0]);
    check_eq("perf1_grants", perf1_grants, m_grants[1]);
    check_eq("perf1_stall",  perf1_stall,  m_stall[1]);
`endif
    d_gnt = {m1_gnt, m0_gnt}; d_rv = {m1_rvalid, m0_rvalid};
    d_mreq = memory_req; d_rdata0 = m0_rdata;
    @(posedge clk);
    if (rstn) begin
      if (s_rvalid) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else m_err = 1'b1;
      end
      if (m_gnt != 2'b00) begin
        exp_q.push_back(esel);
        m_prio = ~esel;
      end
`ifdef MEM_PORT_ARB_PERF_EN
      for (int n = 0; n < 2; n++) begin
        if (m_gnt[n] && m_grants[n] != 32'hFFFF_FFFF) m_grants[n]++;
        if (s_req[n] && !m_gnt[n] && m_stall[n] != 32'hFFFF_FFFF) m_stall[n]++;
      end
`endif
    end
  endtask

  task automatic new_txn(input int n);
    s_req[n]   = 1'b1;
    s_addr[n]  = $urandom;
    s_we[n]    = 1'($urandom_range(0, 1));
    s_be[n]    = 4'($urandom_range(0, 15));
    s_wdata[n] = $urandom;
  endtask

  task automatic idle();
    for (int n = 0; n < 2; n++) s_req[n] = 1'b0;
    s_mgnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    s_rstn = 1'b0;
    step(); step();
    s_rstn = 1'b1;
    step();
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
      s_rvalid = 1'b1; s_rdata = $urandom;
      step();
    end
    s_rvalid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_prio = 1'b0; m_err = 1'b0; m_gnt = '0;
    for (int n = 0; n < 2; n++) begin
      s_req[n] = 0; s_addr[n] = '0; s_we[n] = 0; s_be[n] = '0; s_wdata[n] = '0;
    end
    s_rstn = 1'b0;
    idle();
    do_reset();

    // Alternation with continuous requests and single-cycle responses.
    new_txn(0); new_txn(1); s_mgnt = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_rvalid = (exp_q.size() > 0); s_rdata = $urandom;
      step();
      check_eq("alt_seq", 32'(d_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    drain();

    // Single read on port 0.
    idle();
    s_req[0] = 1'b1; s_addr[0] = 32'h100; s_we[0] = 1'b0; s_be[0] = 4'hF; s_mgnt = 1'b1;
    step();
    check_eq("single_gnt", 32'(d_gnt), 32'h1);
    idle(); step();
    s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
    step();
    check_eq("single_rdata", d_rdata0, 32'hDEADBEEF);
    check_eq("single_rv", 32'(d_rv), 32'h1);
    idle();

    // Stall: both requesting, memory not granting; pointer must hold.
    new_txn(0); new_txn(1); s_mgnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_no_gnt", 32'(d_gnt), 32'h0);
    end
    s_mgnt = 1'b1;
    step();
    check_eq("stall_release", 32'(d_gnt), 32'h2);
    drain();

    // Outstanding limit.
    do_reset();
    new_txn(0); new_txn(1); s_mgnt = 1'b1;
    step(); step();
    step();
    check_eq("full_no_req", 32'(d_mreq), 32'h0);
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
    step();
    check_eq("full_rv_port0", 32'(d_rv), 32'h1);
    check_eq("full_req_same_cycle", 32'(d_mreq), 32'h0);
    s_rvalid = 1'b0;
    step();
    check_eq("full_resume", 32'(d_mreq), 32'h1);
    drain();

    // Orphan response sets the sticky error.
    idle();
    s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001;
    step();
    check_eq("orphan_rv", 32'(d_rv), 32'h0);
    idle();
    for (int i = 0; i < 3; i++) step();
    check_eq("err_sticky", 32'(proto_err), 32'h1);

    // Reset with two transactions outstanding; in-flight responses dropped.
    do_reset();
    new_txn(0); new_txn(1); s_mgnt = 1'b1;
    step(); step();
    s_rstn = 1'b0;
    step(); step();
    s_rstn = 1'b1;
    idle();
    step();
    new_txn(0); new_txn(1); s_mgnt = 1'b1;
    step();
    check_eq("post_reset_prio", 32'(d_gnt), 32'h1);
    idle();
    s_rvalid = 1'b1;
    step(); step(); step();
    s_rvalid = 1'b0;
    step();
    check_eq("dropped_err", 32'(proto_err), 32'h1);

    // Randomized traffic with occasional mid-run resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!s_req[n] && $urandom_range(0, 2) == 0) new_txn(n);
      end
      s_mgnt   = ($urandom_range(0, 3) != 0);
      s_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      s_rdata  = $urandom;
      s_rstn   = ($urandom_range(0, 399) != 0);
      step();
      for (int n = 0; n < 2; n++) begin
        if (m_gnt[n]) s_req[n] = 1'b0;
      end
    end
    s_rstn = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
